butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter WIDTH, default 16, signed data width of every real/imag sample.
REQ-002 Parameter TW_WIDTH, default 16, signed twiddle width, format Q1.(TW_WIDTH-1).
REQ-003 Parameter RH, default 0, rounding constant (0 = truncate, 1 = round half up) added before the scaling shift.
REQ-004 clock  input  1  single clock; every register updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 di_en  input  1  input sample pair valid this cycle.
REQ-007 x0_re, x0_im, x1_re, x1_im  input  WIDTH each  signed butterfly operands.
REQ-008 tw_re, tw_im  input  TW_WIDTH each  signed twiddle, sampled with di_en.
REQ-009 scale_en  input  1  per-pair mode, sampled with di_en: 1 = halve outputs, 0 = full scale with saturation.
REQ-010 ovf_clr  input  1  clears the sticky overflow flag.
REQ-011 do_en  output  1  output pair valid.
REQ-012 y0_re, y0_im, y1_re, y1_im  output  WIDTH each  signed results.
REQ-013 ovf  output  1  sticky saturation flag.

Function
REQ-014 Three register stages; fixed latency: a pair accepted with di_en at edge N SHALL appear with do_en=1 after edge N+3.
REQ-015 Full throughput: one pair per cycle, no backpressure, no bubbles inserted; do_en is di_en delayed by exactly 3 cycles.
REQ-016 Stage 1: add = x0+x1, sub = x0-x1, both WIDTH+1 bits, no loss; twiddle and scale_en travel alongside.
REQ-017 Stage 2: p = sub*tw as a full-precision complex product (re = sr*tr - si*ti, im = sr*ti + si*tr), then + 2^(TW_WIDTH-2) and arithmetic shift right by TW_WIDTH-1, result WIDTH+2 bits; add is delayed one stage unchanged.
REQ-018 Stage 3, scale_en=1: y0 = (add+RH)>>>1, y1 = (p+RH)>>>1, each then saturated to WIDTH.
REQ-019 Stage 3, scale_en=0: y0 = add, y1 = p, each saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 Any saturation event on a valid pair SHALL set ovf at the same edge the pair is output; ovf stays 1 until ovf_clr.
REQ-021 Saturation events on cycles with do_en=0 SHALL NOT set ovf.
REQ-022 ovf_clr and a new saturation event in the same cycle: set wins, ovf=1.
REQ-023 When do_en=0, y outputs SHALL hold their last valid values.
REQ-024 Twiddle -2^(TW_WIDTH-1) is legal; the WIDTH+2 intermediate SHALL absorb it without wrap.

Reset
REQ-025 reset SHALL immediately clear all valid bits, do_en=0, ovf=0, and all y outputs and data registers to 0.
REQ-026 Pairs in flight at reset assertion are discarded; no do_en pulse SHALL occur for them after release.
REQ-027 The first di_en sampled after reset deassertion is processed normally with latency 3.

Structure
REQ-028 A shared package holds the stage count (3) and the saturate-to-WIDTH function used in both scaling modes.
REQ-029 One sub-module, cmul, implements the stage-2 complex multiply with rounding, parameterised by WIDTH+1 and TW_WIDTH.

Verification (WIDTH=16, TW_WIDTH=16, RH=0)
REQ-030 x0=(1000,200), x1=(600,-100), tw=(16384,0), scale_en=1 -> 3 cycles later do_en=1, y0=(800,50), y1=(100,75), ovf=0.
REQ-031 Same x, tw=(0,-16384), scale_en=1 -> y0=(800,50), y1=(75,-100).
REQ-032 x0=(30000,0), x1=(10000,0), tw=(16384,0), scale_en=0 -> y0=(32767,0), y1=(10000,0), ovf=1 and stays 1; ovf_clr pulse -> ovf=0; ovf_clr coincident with new saturation -> ovf=1.
REQ-033 8 back-to-back di_en pairs with alternating scale_en -> 8 consecutive do_en cycles starting 3 cycles after the first, each result matching its own mode.
REQ-034 reset asserted asynchronously with 2 pairs in flight -> do_en, ovf, and y outputs go to 0 immediately; no do_en after release until a new di_en plus 3 cycles.

Source files
------------

// File: rtl/butterfly_pipe_pkg.sv
// Shared definitions for the radix-2 butterfly pipeline.
//   STAGES : number of register stages between di_en and do_en
//   sat_to : clamp a wide signed value to a w-bit signed range and
//            report whether clamping happened
package butterfly_pipe_pkg;

  localparam int STAGES = 3;
  // Wide enough for every intermediate the pipeline ever saturates.
  localparam int SAT_W  = 64;

  typedef struct packed {
    logic                    hit;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  function automatic sat_t sat_to(input logic signed [SAT_W-1:0] v, input int w);
    sat_t                    r;
    logic signed [SAT_W-1:0] hi, lo;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.hit = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.hit = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.hit = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// Data-path bundle of the butterfly pipeline.
//   master : source side (drives di_en, operands, twiddle, modes, ovf_clr)
//   slave  : butterfly side (drives do_en, results, ovf)
interface butterfly_pipe_if #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
);
  logic                       di_en;
  logic signed [WIDTH-1:0]    x0_re, x0_im, x1_re, x1_im;
  logic signed [TW_WIDTH-1:0] tw_re, tw_im;
  logic                       scale_en;
  logic                       ovf_clr;
  logic                       do_en;
  logic signed [WIDTH-1:0]    y0_re, y0_im, y1_re, y1_im;
  logic                       ovf;

  modport master (
    output di_en, x0_re, x0_im, x1_re, x1_im, tw_re, tw_im, scale_en, ovf_clr,
    input  do_en, y0_re, y0_im, y1_re, y1_im, ovf
  );

  modport slave (
    input  di_en, x0_re, x0_im, x1_re, x1_im, tw_re, tw_im, scale_en, ovf_clr,
    output do_en, y0_re, y0_im, y1_re, y1_im, ovf
  );
endinterface

// File: rtl/butterfly_pipe_cmul.sv
// Complex multiply with round-half-up rescale of a Q1.(TW-1) twiddle.
//   sr, si : AW-bit signed operand
//   tr, ti : TW-bit signed twiddle
//   pr, pi : (AW+1)-bit result = (s*t + 2^(TW-2)) >>> (TW-1)
// The extra output bit absorbs the -1.0 twiddle (-2^(TW-1)) without wrap.
module cmul #(
  parameter int AW = 17,
  parameter int TW = 16
) (
  input  logic signed [AW-1:0] sr,
  input  logic signed [AW-1:0] si,
  input  logic signed [TW-1:0] tr,
  input  logic signed [TW-1:0] ti,
  output logic signed [AW:0]   pr,
  output logic signed [AW:0]   pi
);
  // Full-precision width: product plus one bit for the sum of two products.
  localparam int FW = AW + TW + 1;
  localparam int OW = AW + 1;
  localparam logic signed [FW-1:0] HALF = FW'(1) <<< (TW - 2);

  logic signed [FW-1:0] rr, ii, ri, ir, re_f, im_f;

  always_comb begin
    rr   = FW'(sr) * FW'(tr);
    ii   = FW'(si) * FW'(ti);
    ri   = FW'(sr) * FW'(ti);
    ir   = FW'(si) * FW'(tr);
    re_f = rr - ii + HALF;
    im_f = ri + ir + HALF;
    pr   = OW'(re_f >>> (TW - 1));
    pi   = OW'(im_f >>> (TW - 1));
  end
endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIF butterfly: y0 = x0+x1, y1 = (x0-x1)*tw.
//   clock, reset : rising-edge clock, async active-high reset
//   bus          : butterfly_pipe_if.slave (operands in, results out)
// Stage 1 forms sum/difference, stage 2 applies the twiddle, stage 3
// optionally halves and saturates to WIDTH. do_en is di_en delayed by
// STAGES cycles; y outputs hold between valid pairs; ovf is sticky.
module butterfly_pipe
  import butterfly_pipe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int RH       = 0
) (
  input  logic            clock,
  input  logic            reset,
  butterfly_pipe_if.slave bus
);
  localparam int AW = WIDTH + 1;
  localparam int PW = WIDTH + 2;

  logic [STAGES:0] vld_pipe;

  // Stage 1 registers
  logic signed [AW-1:0]       s1_add_re, s1_add_im, s1_sub_re, s1_sub_im;
  logic signed [TW_WIDTH-1:0] s1_tw_re, s1_tw_im;
  logic                       s1_scale;

  // Stage 2 registers
  logic signed [AW-1:0] s2_add_re, s2_add_im;
  logic signed [PW-1:0] s2_p_re, s2_p_im;
  logic                 s2_scale;
  logic signed [PW-1:0] p_re, p_im;

  // Stage 3
  logic signed [SAT_W-1:0] w0_re, w0_im, w1_re, w1_im;
  sat_t                    sat0_re, sat0_im, sat1_re, sat1_im;
  logic                    hit_any;
  logic signed [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;
  logic                    ovf;

  assign vld_pipe[0] = bus.di_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_pipe[STAGES:1] <= '0;
    else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Stage 1: widen by one bit so sum and difference are exact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_add_re <= '0; s1_add_im <= '0;
      s1_sub_re <= '0; s1_sub_im <= '0;
      s1_tw_re  <= '0; s1_tw_im  <= '0;
      s1_scale  <= 1'b0;
    end else if (vld_pipe[0]) begin
      s1_add_re <= AW'(bus.x0_re) + AW'(bus.x1_re);
      s1_add_im <= AW'(bus.x0_im) + AW'(bus.x1_im);
      s1_sub_re <= AW'(bus.x0_re) - AW'(bus.x1_re);
      s1_sub_im <= AW'(bus.x0_im) - AW'(bus.x1_im);
      s1_tw_re  <= bus.tw_re;
      s1_tw_im  <= bus.tw_im;
      s1_scale  <= bus.scale_en;
    end
  end

  // Stage 2: twiddle multiply on the difference path.
  cmul #(.AW(AW), .TW(TW_WIDTH)) u_cmul (
    .sr (s1_sub_re),
    .si (s1_sub_im),
    .tr (s1_tw_re),
    .ti (s1_tw_im),
    .pr (p_re),
    .pi (p_im)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_add_re <= '0; s2_add_im <= '0;
      s2_p_re   <= '0; s2_p_im   <= '0;
      s2_scale  <= 1'b0;
    end else if (vld_pipe[1]) begin
      s2_add_re <= s1_add_re;
      s2_add_im <= s1_add_im;
      s2_p_re   <= p_re;
      s2_p_im   <= p_im;
      s2_scale  <= s1_scale;
    end
  end

  // Stage 3: optional halving, then clamp to WIDTH in either mode.
  always_comb begin
    if (s2_scale) begin
      w0_re = (SAT_W'(s2_add_re) + SAT_W'(RH)) >>> 1;
      w0_im = (SAT_W'(s2_add_im) + SAT_W'(RH)) >>> 1;
      w1_re = (SAT_W'(s2_p_re)   + SAT_W'(RH)) >>> 1;
      w1_im = (SAT_W'(s2_p_im)   + SAT_W'(RH)) >>> 1;
    end else begin
      w0_re = SAT_W'(s2_add_re);
      w0_im = SAT_W'(s2_add_im);
      w1_re = SAT_W'(s2_p_re);
      w1_im = SAT_W'(s2_p_im);
    end
    sat0_re = sat_to(w0_re, WIDTH);
    sat0_im = sat_to(w0_im, WIDTH);
    sat1_re = sat_to(w1_re, WIDTH);
    sat1_im = sat_to(w1_im, WIDTH);
    hit_any = sat0_re.hit | sat0_im.hit | sat1_re.hit | sat1_im.hit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      y0_re <= '0; y0_im <= '0;
      y1_re <= '0; y1_im <= '0;
    end else if (vld_pipe[STAGES-1]) begin
      y0_re <= WIDTH'(sat0_re.val);
      y0_im <= WIDTH'(sat0_im.val);
      y1_re <= WIDTH'(sat1_re.val);
      y1_im <= WIDTH'(sat1_im.val);
    end
  end

  // Stale stage-2 data between pairs must not raise ovf, hence the valid
  // gate; a saturation on the output edge beats a coincident clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              ovf <= 1'b0;
    else if (vld_pipe[STAGES-1] && hit_any) ovf <= 1'b1;
    else if (bus.ovf_clr)                   ovf <= 1'b0;
  end

  assign bus.do_en = vld_pipe[STAGES];
  assign bus.y0_re = y0_re;
  assign bus.y0_im = y0_im;
  assign bus.y1_re = y1_re;
  assign bus.y1_im = y1_im;
  assign bus.ovf   = ovf;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe (WIDTH=16, TW_WIDTH=16, RH=0).
module tb_butterfly_pipe;
  localparam int W  = 16;
  localparam int TW = 16;
  localparam int RH = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  butterfly_pipe_if #(.WIDTH(W), .TW_WIDTH(TW)) bus ();

  butterfly_pipe #(.WIDTH(W), .TW_WIDTH(TW), .RH(RH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int y0r, y0i, y1r, y1i;
    bit hit;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_y0r = 0, last_y1i = 0;
  bit   m_ovf = 0, clr_prev = 0, hit_now;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input longint v, inout bit hit);
    longint hi, lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (v > hi) begin hit = 1; return int'(hi); end
    if (v < lo) begin hit = 1; return int'(lo); end
    return int'(v);
  endfunction

  function automatic exp_t model(input int x0r, x0i, x1r, x1i, tr, ti, input bit sc);
    exp_t   e;
    longint ar, ai, sr, si, pr, pi, half;
    ar   = longint'(x0r) + x1r;
    ai   = longint'(x0i) + x1i;
    sr   = longint'(x0r) - x1r;
    si   = longint'(x0i) - x1i;
    half = longint'(1) << (TW - 2);
    pr   = (sr * tr - si * ti + half) >>> (TW - 1);
    pi   = (sr * ti + si * tr + half) >>> (TW - 1);
    if (sc) begin
      ar = (ar + RH) >>> 1; ai = (ai + RH) >>> 1;
      pr = (pr + RH) >>> 1; pi = (pi + RH) >>> 1;
    end
    e.hit = 0;
    e.cyc = 0;
    e.y0r = clip(ar, e.hit);
    e.y0i = clip(ai, e.hit);
    e.y1r = clip(pr, e.hit);
    e.y1i = clip(pi, e.hit);
    return e;
  endfunction

  function automatic exp_t mk(input int a, b, c, d, input bit h);
    exp_t e;
    e.cyc = 0; e.y0r = a; e.y0i = b; e.y1r = c; e.y1i = d; e.hit = h;
    return e;
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic drive(input int x0r, x0i, x1r, x1i, tr, ti, input bit sc,
                       input bit clr, input exp_t e);
    @(posedge clock); #1;
    bus.di_en    = 1'b1;
    bus.x0_re    = W'(x0r);  bus.x0_im = W'(x0i);
    bus.x1_re    = W'(x1r);  bus.x1_im = W'(x1i);
    bus.tw_re    = TW'(tr);  bus.tw_im = TW'(ti);
    bus.scale_en = sc;
    bus.ovf_clr  = clr;
    e.cyc = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic send(input int x0r, x0i, x1r, x1i, tr, ti, input bit sc, input bit clr);
    drive(x0r, x0i, x1r, x1i, tr, ti, sc, clr, model(x0r, x0i, x1r, x1i, tr, ti, sc));
  endtask

  task automatic idle(input int n, input bit clr);
    repeat (n) begin
      @(posedge clock); #1;
      bus.di_en   = 1'b0;
      bus.ovf_clr = clr;
    end
  endtask

  // Output monitor: pops the scoreboard on do_en, checks hold otherwise,
  // and tracks the sticky flag (ovf_clr seen here is sampled at the next edge).
  always @(negedge clock) begin
    if (reset) begin
      m_ovf = 0; clr_prev = 0; last_y0r = 0; last_y1i = 0;
    end else begin
      hit_now = 0;
      if (bus.do_en) begin
        if (sb.size() == 0) begin
          chk("spurious_do_en", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", cyc, mon_e.cyc);
          chk("y0_re", bus.y0_re, mon_e.y0r);
          chk("y0_im", bus.y0_im, mon_e.y0i);
          chk("y1_re", bus.y1_re, mon_e.y1r);
          chk("y1_im", bus.y1_im, mon_e.y1i);
          hit_now  = mon_e.hit;
          last_y0r = mon_e.y0r;
          last_y1i = mon_e.y1i;
        end
      end else begin
        chk("hold_y0_re", bus.y0_re, last_y0r);
        chk("hold_y1_im", bus.y1_im, last_y1i);
      end
      if (hit_now)       m_ovf = 1;
      else if (clr_prev) m_ovf = 0;
      chk("ovf", bus.ovf, m_ovf);
      clr_prev = bus.ovf_clr;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_do_en"}, bus.do_en, 0);
    chk({tag, "_ovf"},   bus.ovf,   0);
    chk({tag, "_y0_re"}, bus.y0_re, 0);
    chk({tag, "_y0_im"}, bus.y0_im, 0);
    chk({tag, "_y1_re"}, bus.y1_re, 0);
    chk({tag, "_y1_im"}, bus.y1_im, 0);
  endtask

  initial begin
    bus.di_en = 0; bus.scale_en = 0; bus.ovf_clr = 0;
    bus.x0_re = 0; bus.x0_im = 0; bus.x1_re = 0; bus.x1_im = 0;
    bus.tw_re = 0; bus.tw_im = 0;

    // Reset state
    @(posedge clock); #1;
    chk_reset_state("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed vectors with hand-derived results
    drive(1000, 200, 600, -100, 16384, 0,      1, 0, mk(800, 50, 100, 75, 0));
    drive(1000, 200, 600, -100, 0,     -16384, 1, 0, mk(800, 50, 75, -100, 0));
    idle(4, 0);
    drive(30000, 0, 10000, 0, 16384, 0, 0, 0, mk(32767, 0, 10000, 0, 1));
    idle(6, 0);                       // ovf stays set
    idle(1, 1);                       // clear pulse
    idle(4, 0);                       // stale saturating data must not re-set
    // Saturating pair with clear landing on its output edge: set wins.
    drive(30000, 0, 10000, 0, 16384, 0, 0, 0, mk(32767, 0, 10000, 0, 1));
    idle(1, 0);
    idle(1, 1);
    idle(4, 0);
    idle(1, 1);
    idle(3, 0);

    // Eight back-to-back pairs, alternating mode
    for (int i = 0; i < 8; i++)
      send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), i[0], 0);
    idle(5, 0);

    // -1.0 twiddle and extreme operands
    send(32767, -32768, -32768, 32767, -32768, 0,      0, 0);
    send(32767, -32768, -32768, 32767, -32768, -32768, 0, 0);
    send(32767, -32768, -32768, 32767, -32768, -32768, 1, 0);
    send(-32768, 32767, 32767, -32768, -32768, 32767,  1, 0);
    send(-20000, 5, 20000, -7, -32768, 0,              1, 0);
    idle(5, 1);
    idle(2, 0);

    // Random traffic with random gaps and clears
    for (int i = 0; i < 40; i++) begin
      send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
           1'($urandom_range(1)), ($urandom_range(9) == 0));
      if ($urandom_range(3) == 0) idle($urandom_range(3) + 1, 0);
    end
    idle(5, 0);

    // Asynchronous reset with two pairs in flight (ovf set beforehand)
    drive(30000, 0, 10000, 0, 16384, 0, 0, 0, mk(32767, 0, 10000, 0, 1));
    idle(4, 0);
    send(1234, -55, 321, 77, 16384, 16384, 1, 0);
    send(-999, 4000, 17, -3, -16384, 5000, 0, 0);
    @(posedge clock); #1;
    bus.di_en = 0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async_rst");
    sb.delete();
    idle(2, 0);
    reset = 1'b0;
    idle(6, 0);                       // any do_en here is spurious
    send(1000, 200, 600, -100, 16384, 0, 1, 0);
    idle(6, 0);

    chk("drain_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
